bpr_multi_averager: RTL and testbench
=====================================

# bpr_multi_averager

Parametrised, pipelined neighbour averager for the bad pixel replacer. It takes NUM_INPUTS neighbour pixels, each tagged with a good flag, and outputs the rounded mean of the good ones together with the good-neighbour count. When every neighbour is bad, it can optionally hold the last good average. It sits between the neighbour-window gatherer and the replacement mux, and generalises the two-input averager to N inputs and arbitrary pixel width, with valid tracking.

## Interface
- DATA_WIDTH, 14: pixel payload bits. Each lane is DATA_WIDTH+1 bits; bit DATA_WIDTH is the good flag (1 = good).
- NUM_INPUTS, 4: number of neighbour lanes, legal range 2..8.
- CNT_WIDTH, $clog2(NUM_INPUTS+1): width of the good-count output (derived; do not override).

- clk  in  1  system clock
- srst  in  1  synchronous reset, active-high; acts only on a clk edge where cen=1
- cen  in  1  clock enable; no state changes when cen=0
- pix_in_valid  in  1  the pix_in set is valid this cycle
- pix_in  in  NUM_INPUTS*(DATA_WIDTH+1)  lane i at [i*(DATA_WIDTH+1) +: DATA_WIDTH+1]
- hold_last_en  in  1  all-bad policy for this item (1 = hold last good, 0 = output zero); sampled together with pix_in
- pix_out  out  DATA_WIDTH+1  averaged pixel; MSB is the good flag
- pix_out_valid  out  1  pix_out and good_cnt are valid
- good_cnt  out  CNT_WIDTH  number of good lanes in this item, aligned with pix_out

## Operation
- Let k be the number of lanes with the flag set, and S the sum of their payloads. S needs DATA_WIDTH+3 bits for N≤8; no overflow is permitted.
- k≥1: pix_out = {1'b1, floor((S + floor(k/2)) / k)}.
  - This is round-half-up and must be bit-exact for every k in 1..NUM_INPUTS.
  - The implementation may use a constant reciprocal multiply, provided it is proven exact over the full input range; a divider is not required.
  - For NUM_INPUTS=2 this reduces to (a+b+1)>>1.
- k=0, hold_last_en=1: pix_out = {1'b0, last_good}.
- k=0, hold_last_en=0: pix_out = all zeros.
- last_good register:
  - Updated with the result payload on every output with pix_out_valid=1 and k≥1.
  - An all-bad item uses the value from before that item, so it never sees its own result.
  - Consecutive all-bad items all output the same held value.
- Invalid items (pix_in_valid=0) travel through the pipe as bubbles. They never update last_good. pix_out and good_cnt hold their previous values during bubbles.
- Reset values: pix_out=0, pix_out_valid=0, good_cnt=0, last_good=0, all pipeline valid bits 0.

## Timing
- Latency is exactly 4 cen-qualified cycles from the sample edge of pix_in to pix_out_valid, independent of NUM_INPUTS.
  - Stage 1: input register and flag masking.
  - Stage 2: adder tree and popcount.
  - Stage 3: rounding add and scaling.
  - Stage 4: policy select, last_good update and output register.
- Throughput is one item per enabled cycle; there is no backpressure.
- cen=0 freezes every stage, including the valid pipeline. pix_out_valid keeps its value but must not be counted twice by the consumer.
- srst with cen=1 discards in-flight items. From the next edge, outputs and last_good hold reset values.
- srst with cen=0 is ignored.
- Simultaneous srst and pix_in_valid: the input is discarded.
- Reset mid-hold: last_good returns to 0, so a following all-bad item with hold outputs 0.

## Test plan
- N=4, W=14, lanes {good 100, good 101, good 102, good 104} -> after 4 cycles: pix_out={1,102} (407+2=409, /4=102), good_cnt=4, valid=1.
- N=4, lanes 0 and 2 good, values 7 and 8 -> {1,8} (15+1=16, /2=8), good_cnt=2. Single good lane 16383 -> {1,16383}, good_cnt=1.
- N=8, all lanes good at 16383 -> {1,16383} with no overflow. Three good lanes 1,1,2 -> {1,1} (4+1=5, /3=1).
- Item with good avg 500, then two all-bad items with hold_last_en=1, then one all-bad item with hold_last_en=0 -> outputs {1,500}, {0,500}, {0,500}, {0,0}.
- Back-to-back valid items with cen toggled 1,0,1,1,0,1 -> each result appears exactly 4 enabled cycles after its input. Results are unchanged across cen=0 cycles.
- Three items in flight, then srst=1 with cen=1 -> pix_out_valid=0 and pix_out=0 from the next edge. None of the in-flight results appear. A subsequent all-bad item with hold -> {0,0}.

Source files
------------

// File: rtl/bpr_multi_averager.sv
// bpr_multi_averager
// Four-stage pipelined rounded-mean of the good lanes among NUM_INPUTS
// neighbour pixels, for the bad pixel replacer.
//
// Ports
//   clk           system clock
//   srst          synchronous active-high reset, only effective when cen=1
//   cen           clock enable; cen=0 freezes every stage
//   pix_in_valid  pix_in set is valid this cycle
//   pix_in        NUM_INPUTS lanes of {good, payload[DATA_WIDTH-1:0]}
//   hold_last_en  all-bad policy for this item (1 = hold last good, 0 = zero)
//   pix_out       {good, averaged payload}
//   pix_out_valid pix_out / good_cnt carry a new item this cycle
//   good_cnt      number of good lanes of the item on pix_out
//
// Stages
//   1: input register, payloads of bad lanes forced to zero
//   2: sum of payloads and popcount of flags
//   3: round-half-up add of floor(k/2), divide by k
//   4: all-bad policy, last_good update, output register

module bpr_multi_averager #(
    parameter int DATA_WIDTH = 14,
    parameter int NUM_INPUTS = 4,
    parameter int CNT_WIDTH  = $clog2(NUM_INPUTS + 1)
) (
    input  logic                                   clk,
    input  logic                                   srst,
    input  logic                                   cen,
    input  logic                                   pix_in_valid,
    input  logic [NUM_INPUTS*(DATA_WIDTH+1)-1:0]   pix_in,
    input  logic                                   hold_last_en,
    output logic [DATA_WIDTH:0]                    pix_out,
    output logic                                   pix_out_valid,
    output logic [CNT_WIDTH-1:0]                   good_cnt
);

    localparam int LANE_W = DATA_WIDTH + 1;
    // 8 * (2^W - 1) + floor(8/2) < 2^(W+3), so the rounded sum never overflows.
    localparam int SUM_W  = DATA_WIDTH + 3;

    // ---------------- stage 1 ----------------
    logic [DATA_WIDTH-1:0] s1_data_d [NUM_INPUTS];
    logic [DATA_WIDTH-1:0] s1_data_q [NUM_INPUTS];
    logic [NUM_INPUTS-1:0] s1_flag_d, s1_flag_q;
    logic                  s1_hold_q;
    logic                  s1_valid_q;

    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            s1_flag_d[i] = pix_in[i*LANE_W + DATA_WIDTH];
            s1_data_d[i] = s1_flag_d[i] ? pix_in[i*LANE_W +: DATA_WIDTH] : '0;
        end
    end

    // ---------------- stage 2 ----------------
    logic [SUM_W-1:0]     s2_sum_d, s2_sum_q;
    logic [CNT_WIDTH-1:0] s2_cnt_d, s2_cnt_q;
    logic                 s2_hold_q;
    logic                 s2_valid_q;

    always_comb begin
        s2_sum_d = '0;
        s2_cnt_d = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            s2_sum_d = s2_sum_d + SUM_W'(s1_data_q[i]);
            s2_cnt_d = s2_cnt_d + CNT_WIDTH'(s1_flag_q[i]);
        end
    end

    // ---------------- stage 3 ----------------
    logic [SUM_W-1:0]      s2_rnd;
    logic [DATA_WIDTH-1:0] s3_quot_d, s3_quot_q;
    logic [CNT_WIDTH-1:0]  s3_cnt_q;
    logic                  s3_hold_q;
    logic                  s3_valid_q;

    // One constant divisor per possible k; only the branch matching the
    // popcount is selected, so each divider is exact by construction.
    // The quotient of a rounded mean never exceeds the largest payload,
    // so truncating to DATA_WIDTH loses nothing.
    always_comb begin
        s2_rnd    = s2_sum_q + SUM_W'(s2_cnt_q >> 1);
        s3_quot_d = '0;
        for (int d = 1; d <= NUM_INPUTS; d++) begin
            if (s2_cnt_q == CNT_WIDTH'(d)) begin
                s3_quot_d = DATA_WIDTH'(s2_rnd / SUM_W'(d));
            end
        end
    end

    // ---------------- stage 4 ----------------
    logic [DATA_WIDTH:0]   result;
    logic [DATA_WIDTH:0]   pix_out_d, pix_out_q;
    logic [CNT_WIDTH-1:0]  good_cnt_d, good_cnt_q;
    logic [DATA_WIDTH-1:0] last_good_d, last_good_q;
    logic                  pix_out_valid_q;

    always_comb begin
        if (s3_cnt_q != '0) begin
            result = {1'b1, s3_quot_q};
        end else if (s3_hold_q) begin
            // last_good_q still holds the value from before this item
            result = {1'b0, last_good_q};
        end else begin
            result = '0;
        end

        pix_out_d   = pix_out_q;
        good_cnt_d  = good_cnt_q;
        last_good_d = last_good_q;
        if (s3_valid_q) begin
            pix_out_d  = result;
            good_cnt_d = s3_cnt_q;
            if (s3_cnt_q != '0) begin
                last_good_d = s3_quot_q;
            end
        end
    end

    // Control and observable state: reset and enable.
    always_ff @(posedge clk) begin
        if (cen) begin
            if (srst) begin
                s1_valid_q      <= 1'b0;
                s2_valid_q      <= 1'b0;
                s3_valid_q      <= 1'b0;
                pix_out_valid_q <= 1'b0;
                pix_out_q       <= '0;
                good_cnt_q      <= '0;
                last_good_q     <= '0;
            end else begin
                s1_valid_q      <= pix_in_valid;
                s2_valid_q      <= s1_valid_q;
                s3_valid_q      <= s2_valid_q;
                pix_out_valid_q <= s3_valid_q;
                pix_out_q       <= pix_out_d;
                good_cnt_q      <= good_cnt_d;
                last_good_q     <= last_good_d;
            end
        end
    end

    // Datapath registers need no reset: their contents are only used
    // when the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (cen) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                s1_data_q[i] <= s1_data_d[i];
            end
            s1_flag_q <= s1_flag_d;
            s1_hold_q <= hold_last_en;
            s2_sum_q  <= s2_sum_d;
            s2_cnt_q  <= s2_cnt_d;
            s2_hold_q <= s1_hold_q;
            s3_quot_q <= s3_quot_d;
            s3_cnt_q  <= s2_cnt_q;
            s3_hold_q <= s2_hold_q;
        end
    end

    assign pix_out       = pix_out_q;
    assign pix_out_valid = pix_out_valid_q;
    assign good_cnt      = good_cnt_q;

endmodule

// File: tb/tb_bpr_multi_averager.sv
module tb_bpr_multi_averager;

    logic         clk = 1'b0;
    logic         srst, cen;
    logic         pix4_valid, hold4, v4;
    logic [59:0]  pix4;
    logic [14:0]  pix4_out;
    logic [2:0]   cnt4;
    logic         pix8_valid, hold8, v8;
    logic [119:0] pix8;
    logic [14:0]  pix8_out;
    logic [3:0]   cnt8;

    always #5 clk = ~clk;

    bpr_multi_averager #(.DATA_WIDTH(14), .NUM_INPUTS(4)) dut4 (
        .clk(clk), .srst(srst), .cen(cen), .pix_in_valid(pix4_valid),
        .pix_in(pix4), .hold_last_en(hold4), .pix_out(pix4_out),
        .pix_out_valid(v4), .good_cnt(cnt4)
    );

    bpr_multi_averager #(.DATA_WIDTH(14), .NUM_INPUTS(8)) dut8 (
        .clk(clk), .srst(srst), .cen(cen), .pix_in_valid(pix8_valid),
        .pix_in(pix8), .hold_last_en(hold8), .pix_out(pix8_out),
        .pix_out_valid(v8), .good_cnt(cnt8)
    );

    typedef struct {
        logic [14:0] pix;
        int          cnt;
        int          edge_idx;
    } exp_t;

    exp_t q4[$];
    exp_t q8[$];
    int   total = 0;
    int   bad   = 0;
    int   en_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    logic        mon_en;
    exp_t        mon_e;
    logic [14:0] last4;
    int          lastc4;
    logic        seen4 = 1'b0;

    always @(posedge clk) begin
        mon_en = cen;
        if (mon_en) en_cnt++;
        #1;
        if (mon_en) begin
            if (v4) begin
                if (q4.size() == 0) begin
                    total++; bad++;
                    $display("FAIL d4_unexpected: got pix=%0h cnt=%0d expected no output", pix4_out, cnt4);
                end else begin
                    mon_e = q4.pop_front();
                    chk("d4_pix", 32'(pix4_out), 32'(mon_e.pix));
                    chk("d4_cnt", 32'(cnt4), 32'(mon_e.cnt));
                    chk("d4_latency", 32'(en_cnt), 32'(mon_e.edge_idx));
                    last4  = mon_e.pix;
                    lastc4 = mon_e.cnt;
                    seen4  = 1'b1;
                end
            end
            if (v8) begin
                if (q8.size() == 0) begin
                    total++; bad++;
                    $display("FAIL d8_unexpected: got pix=%0h cnt=%0d expected no output", pix8_out, cnt8);
                end else begin
                    mon_e = q8.pop_front();
                    chk("d8_pix", 32'(pix8_out), 32'(mon_e.pix));
                    chk("d8_cnt", 32'(cnt8), 32'(mon_e.cnt));
                    chk("d8_latency", 32'(en_cnt), 32'(mon_e.edge_idx));
                end
            end
        end else if (seen4) begin
            chk("d4_frozen_pix", 32'(pix4_out), 32'(last4));
            chk("d4_frozen_cnt", 32'(cnt4), 32'(lastc4));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input logic c);
        cen = c;
        @(negedge clk);
        pix4_valid = 1'b0;
        pix8_valid = 1'b0;
    endtask

    task automatic set4(input logic [3:0] g, input int a, input int b, input int c, input int d);
        pix4[0*15 +: 15] = {g[0], 14'(a)};
        pix4[1*15 +: 15] = {g[1], 14'(b)};
        pix4[2*15 +: 15] = {g[2], 14'(c)};
        pix4[3*15 +: 15] = {g[3], 14'(d)};
    endtask

    task automatic set8(input logic [7:0] g, input int a, input int b, input int c, input int d,
                        input int e, input int f, input int h, input int k);
        pix8[0*15 +: 15] = {g[0], 14'(a)};
        pix8[1*15 +: 15] = {g[1], 14'(b)};
        pix8[2*15 +: 15] = {g[2], 14'(c)};
        pix8[3*15 +: 15] = {g[3], 14'(d)};
        pix8[4*15 +: 15] = {g[4], 14'(e)};
        pix8[5*15 +: 15] = {g[5], 14'(f)};
        pix8[6*15 +: 15] = {g[6], 14'(h)};
        pix8[7*15 +: 15] = {g[7], 14'(k)};
    endtask

    // Caller guarantees cen=1 on the following edge, so the result is
    // due after the 4th enabled edge counting the sample edge.
    task automatic arm4(input logic hold, input logic [14:0] exp_pix, input int exp_cnt);
        exp_t e;
        pix4_valid = 1'b1;
        hold4      = hold;
        e.pix = exp_pix; e.cnt = exp_cnt; e.edge_idx = en_cnt + 4;
        q4.push_back(e);
    endtask

    task automatic arm8(input logic hold, input logic [14:0] exp_pix, input int exp_cnt);
        exp_t e;
        pix8_valid = 1'b1;
        hold8      = hold;
        e.pix = exp_pix; e.cnt = exp_cnt; e.edge_idx = en_cnt + 4;
        q8.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (q4.size() != 0 || q8.size() != 0); i++) cyc(1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        srst = 1'b1; cen = 1'b1;
        pix4_valid = 1'b0; pix8_valid = 1'b0; hold4 = 1'b0; hold8 = 1'b0;
        pix4 = '0; pix8 = '0;
        @(negedge clk);
        repeat (3) cyc(1'b1);
        srst = 1'b0;
        chk("rst_d4_pix", 32'(pix4_out), 32'd0);
        chk("rst_d4_valid", 32'(v4), 32'd0);
        chk("rst_d4_cnt", 32'(cnt4), 32'd0);
        chk("rst_d8_pix", 32'(pix8_out), 32'd0);
        chk("rst_d8_valid", 32'(v8), 32'd0);
        chk("rst_d8_cnt", 32'(cnt8), 32'd0);

        // Basic averages, both widths in parallel.
        set4(4'b1111, 100, 101, 102, 104);   arm4(1'b0, {1'b1, 14'd102}, 4);
        set8(8'hFF, 16383, 16383, 16383, 16383, 16383, 16383, 16383, 16383);
        arm8(1'b0, {1'b1, 14'd16383}, 8);
        cyc(1'b1);
        set4(4'b0101, 7, 5000, 8, 9999);     arm4(1'b0, {1'b1, 14'd8}, 2);
        set8(8'b0101_0010, 900, 1, 77, 66, 1, 55, 2, 44);
        arm8(1'b0, {1'b1, 14'd1}, 3);
        cyc(1'b1);
        set4(4'b1000, 3, 3, 3, 16383);       arm4(1'b0, {1'b1, 14'd16383}, 1);
        set8(8'hFF, 1, 2, 3, 4, 5, 6, 7, 8); arm8(1'b0, {1'b1, 14'd5}, 8);
        cyc(1'b1);
        set4(4'b1111, 499, 500, 501, 500);   arm4(1'b0, {1'b1, 14'd500}, 4);
        set8(8'b0001_1111, 10, 10, 10, 10, 11, 999, 999, 999);
        arm8(1'b0, {1'b1, 14'd10}, 5);
        cyc(1'b1);
        set4(4'b0000, 1, 2, 3, 4);           arm4(1'b1, {1'b0, 14'd500}, 0);
        set8(8'b0011_1111, 3, 3, 3, 3, 3, 4, 500, 600);
        arm8(1'b0, {1'b1, 14'd3}, 6);
        cyc(1'b1);
        set4(4'b0000, 9, 9, 9, 9);           arm4(1'b1, {1'b0, 14'd500}, 0);
        set8(8'b0111_1111, 0, 0, 0, 0, 0, 0, 4, 1000);
        arm8(1'b0, {1'b1, 14'd1}, 7);
        cyc(1'b1);
        set4(4'b0000, 9, 9, 9, 9);           arm4(1'b0, 15'd0, 0);
        set8(8'h00, 5, 5, 5, 5, 5, 5, 5, 5); arm8(1'b1, {1'b0, 14'd1}, 0);
        cyc(1'b1);
        drain();

        // Back-to-back items under cen pattern 1,0,1,1,0,1.
        set4(4'b1111, 1, 2, 3, 4);           arm4(1'b0, {1'b1, 14'd3}, 4);
        cyc(1'b1);
        cyc(1'b0);
        set4(4'b0111, 10, 20, 30, 7777);     arm4(1'b0, {1'b1, 14'd20}, 3);
        cyc(1'b1);
        set4(4'b1010, 50, 1, 60, 2);         arm4(1'b0, {1'b1, 14'd2}, 2);
        cyc(1'b1);
        cyc(1'b0);
        set4(4'b1111, 16383, 16383, 16383, 16382); arm4(1'b0, {1'b1, 14'd16383}, 4);
        cyc(1'b1);
        cyc(1'b1); cyc(1'b0); cyc(1'b1); cyc(1'b0); cyc(1'b0);
        cyc(1'b1); cyc(1'b1); cyc(1'b0); cyc(1'b1);
        drain();

        // srst while cen=0 must be ignored, last_good survives.
        set4(4'b1111, 40, 40, 40, 40);       arm4(1'b0, {1'b1, 14'd40}, 4);
        cyc(1'b1);
        srst = 1'b1;
        cyc(1'b0);
        srst = 1'b0;
        set4(4'b0000, 0, 0, 0, 0);           arm4(1'b1, {1'b0, 14'd40}, 0);
        cyc(1'b1);
        drain();

        // Three items in flight, then srst with a valid input present.
        set4(4'b1111, 1000, 1000, 1000, 1000); arm4(1'b0, {1'b1, 14'd1000}, 4);
        cyc(1'b1);
        set4(4'b0011, 2000, 2000, 0, 0);     arm4(1'b0, {1'b1, 14'd2000}, 2);
        cyc(1'b1);
        set4(4'b0001, 3000, 0, 0, 0);        arm4(1'b0, {1'b1, 14'd3000}, 1);
        cyc(1'b1);
        set4(4'b1111, 4000, 4000, 4000, 4000); arm4(1'b0, {1'b1, 14'd4000}, 4);
        srst = 1'b1;
        cyc(1'b1);
        srst = 1'b0;
        q4.delete();
        chk("srst_d4_valid", 32'(v4), 32'd0);
        chk("srst_d4_pix", 32'(pix4_out), 32'd0);
        chk("srst_d4_cnt", 32'(cnt4), 32'd0);
        cyc(1'b1);
        chk("srst_d4_valid_next", 32'(v4), 32'd0);
        set4(4'b0000, 7, 7, 7, 7);           arm4(1'b1, 15'd0, 0);
        cyc(1'b1);
        drain();
        repeat (6) cyc(1'b1);

        chk("q4_empty", 32'(q4.size()), 32'd0);
        chk("q8_empty", 32'(q8.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

endmodule
